// File: rtl/entity_collision_scheduler.sv
// N-channel tile-collision sweep: per frame, each channel gets a horizontal and a vertical
// four-corner probe pass through one pipelined tile lookup port. Optional RESOLVE_POS_EN adds res_pos.
module entity_collision_scheduler #(
    parameter int          N_CH        = 4,
    parameter int          HB_W        = 32,
    parameter int          HB_H        = 32,
    parameter int          LOOKUP_LAT  = 1,
    parameter logic [7:0]  SOLID_MASK  = 8'b0000_0010,
    parameter logic [7:0]  ONEWAY_MASK = 8'b0000_0100,
    parameter int          SCREEN_W    = 640,
    parameter int          SCREEN_H    = 480
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sim_clk,
    input  logic [N_CH-1:0]      ch_en,
    input  logic [32*N_CH-1:0]   ch_state,
    output logic [9:0]           tile_x,
    output logic [9:0]           tile_y,
    input  logic [2:0]           tile_type,
    output logic [4*N_CH-1:0]    col,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
`ifdef RESOLVE_POS_EN
    ,
    output logic [20*N_CH-1:0]   res_pos
`endif
);

    localparam int CW       = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PASS_LEN = 4 + LOOKUP_LAT;
    localparam logic signed [11:0] XOFF = 12'(HB_W - 1);
    localparam logic signed [11:0] YOFF = 12'(HB_H - 1);
    localparam logic signed [11:0] SW12 = 12'(SCREEN_W);
    localparam logic signed [11:0] SH12 = 12'(SCREEN_H);

    typedef enum logic [2:0] {S_IDLE, S_SNAP, S_HPASS, S_VPASS, S_LATCH} state_t;

    typedef struct packed {
        logic          valid;
        logic [CW-1:0] ch;
        logic [1:0]    fidx;
        logic          oneway;
        logic          off;
    } tag_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] ch_reg, ch_next;
    logic [3:0]    cyc_reg, cyc_next;

    logic sync1_reg, sync2_reg, sync3_reg;
    logic sim_edge;

    logic [N_CH-1:0]    en_reg;
    logic [32*N_CH-1:0] snap_reg;
    logic [4*N_CH-1:0]  flags_reg, flags_next;
    logic [4*N_CH-1:0]  col_reg, col_next;
    logic               done_reg, overrun_reg;
    logic [9:0]         tile_x_reg, tile_y_reg;

    tag_t tag_reg [0:LOOKUP_LAT];
    tag_t tag_in, res;
    logic hit;

    logic [31:0]        src_word;
    logic [9:0]         sx, sy;
    logic [4:0]         sxs, sys;
    logic               sxd, syd;
    logic               issue_valid, issue_v;
    logic [1:0]         probe;
    logic signed [11:0] x12, y12, xs12, ys12, nx, ny, px, py;

    assign sim_edge = sync2_reg & ~sync3_reg;
    assign busy     = (state_reg != S_IDLE);
    assign done     = done_reg;
    assign overrun  = overrun_reg;
    assign col      = col_reg;
    assign tile_x   = tile_x_reg;
    assign tile_y   = tile_y_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            ch_reg    <= '0;
            cyc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ch_reg    <= ch_next;
            cyc_reg   <= cyc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ch_next    = ch_reg;
        cyc_next   = cyc_reg;
        case (state_reg)
            S_IDLE:  if (sim_edge) state_next = S_SNAP;
            S_SNAP: begin
                state_next = S_HPASS;
                ch_next    = '0;
                cyc_next   = '0;
            end
            S_HPASS: begin
                if (cyc_reg == 4'(PASS_LEN - 1)) begin
                    state_next = S_VPASS;
                    cyc_next   = '0;
                end else begin
                    cyc_next = cyc_reg + 4'd1;
                end
            end
            S_VPASS: begin
                if (cyc_reg == 4'(PASS_LEN - 1)) begin
                    cyc_next = '0;
                    if (ch_reg == CW'(N_CH - 1)) begin
                        state_next = S_LATCH;
                    end else begin
                        state_next = S_HPASS;
                        ch_next    = ch_reg + CW'(1);
                    end
                end else begin
                    cyc_next = cyc_reg + 4'd1;
                end
            end
            S_LATCH: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Probes are computed one cycle ahead so tile_x/tile_y are registered in the issue cycle;
    // the first probe of a frame is built from the live inputs while SNAP captures them.
    always_comb begin
        src_word = (state_reg == S_SNAP) ? ch_state[32*ch_next +: 32] : snap_reg[32*ch_next +: 32];
        {sx, sy, sxs, sys, sxd, syd} = src_word;
        issue_v     = (state_next == S_VPASS);
        issue_valid = ((state_next == S_HPASS) || issue_v) && (cyc_next < 4'd4);
        probe       = cyc_next[1:0];
        x12  = $signed({2'b00, sx});
        y12  = $signed({2'b00, sy});
        xs12 = $signed({7'b0000000, sxs});
        ys12 = $signed({7'b0000000, sys});
        if (issue_v) begin
            nx = x12;
            ny = syd ? (y12 - ys12) : (y12 + ys12);
        end else begin
            nx = sxd ? (x12 + xs12) : (x12 - xs12);
            ny = y12;
        end
        px = nx + (((probe == 2'd2) || (probe == 2'd3)) ? XOFF : 12'sd0);
        py = ny - (((probe == 2'd1) || (probe == 2'd2)) ? YOFF : 12'sd0);
        tag_in.valid  = issue_valid;
        tag_in.ch     = ch_next;
        tag_in.fidx   = issue_v ? (syd ? 2'd3 : 2'd1) : (sxd ? 2'd2 : 2'd0);
        tag_in.oneway = issue_v & ~syd;
        tag_in.off    = (px < 12'sd0) || (px >= SW12) || (py < 12'sd0) || (py >= SH12);
    end

    assign res = tag_reg[LOOKUP_LAT];
    assign hit = res.valid & (res.off | SOLID_MASK[tile_type] | (res.oneway & ONEWAY_MASK[tile_type]));

    always_comb begin
        flags_next = flags_reg;
        for (int i = 0; i < N_CH; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (hit && (res.ch == CW'(i)) && (res.fidx == 2'(j)))
                    flags_next[4*i+j] = 1'b1;
            end
        end
    end

`ifdef RESOLVE_POS_EN
    logic [20*N_CH-1:0] pos_next, pos_reg;
    assign res_pos = pos_reg;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign col_next[4*gi +: 4] = flags_next[4*gi +: 4] & {4{en_reg[gi]}};
`ifdef RESOLVE_POS_EN
            logic [31:0] w;
            logic [9:0]  x, y, nxh, nyv, rx, ry;
            assign w   = snap_reg[32*gi +: 32];
            assign x   = w[31:22];
            assign y   = w[21:12];
            assign nxh = w[1] ? (x + {5'd0, w[11:7]}) : (x - {5'd0, w[11:7]});
            assign nyv = w[0] ? (y - {5'd0, w[6:2]}) : (y + {5'd0, w[6:2]});
            assign rx  = (!en_reg[gi] || flags_next[4*gi] || flags_next[4*gi+2]) ? x : nxh;
            assign ry  = (!en_reg[gi] || flags_next[4*gi+1] || flags_next[4*gi+3]) ? y : nyv;
            assign pos_next[20*gi +: 20] = {rx, ry};
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            sync3_reg   <= 1'b0;
            overrun_reg <= 1'b0;
            en_reg      <= '0;
            snap_reg    <= '0;
            flags_reg   <= '0;
            col_reg     <= '0;
            done_reg    <= 1'b0;
            tile_x_reg  <= '0;
            tile_y_reg  <= '0;
            for (int k = 0; k <= LOOKUP_LAT; k++) tag_reg[k] <= '0;
`ifdef RESOLVE_POS_EN
            pos_reg     <= '0;
`endif
        end else begin
            sync1_reg <= sim_clk;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
            if (sim_edge && (state_reg != S_IDLE)) overrun_reg <= 1'b1;
            if (state_reg == S_SNAP) begin
                en_reg    <= ch_en;
                snap_reg  <= ch_state;
                flags_reg <= '0;
            end else begin
                flags_reg <= flags_next;
            end
            tag_reg[0] <= tag_in;
            for (int k = 1; k <= LOOKUP_LAT; k++) tag_reg[k] <= tag_reg[k-1];
            if (issue_valid) begin
                tile_x_reg <= px[9:0];
                tile_y_reg <= py[9:0];
            end
            done_reg <= (state_next == S_LATCH);
            if (state_next == S_LATCH) begin
                col_reg <= col_next;
`ifdef RESOLVE_POS_EN
                pos_reg <= pos_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_entity_collision_scheduler.sv
// Directed bench: a 1-channel/latency-1 instance and a 4-channel/latency-3 instance,
// each fed by a registered tile-map model with the matching lookup latency.
module tb_entity_collision_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int mode_a = 0;
    int mode_b = 0;

    logic        rst_a_n, sim_a;
    logic [0:0]  en_a;
    logic [31:0] st_a;
    logic [9:0]  tx_a, ty_a;
    logic [2:0]  tt_a;
    logic [3:0]  col_a;
    logic        busy_a, done_a, ovr_a;

    logic         rst_b_n, sim_b;
    logic [3:0]   en_b;
    logic [127:0] st_b;
    logic [9:0]   tx_b, ty_b;
    logic [2:0]   tt_b;
    logic [15:0]  col_b;
    logic         busy_b, done_b, ovr_b;

`ifdef RESOLVE_POS_EN
    logic [19:0] pos_a;
    logic [79:0] pos_b;
`endif

    entity_collision_scheduler #(.N_CH(1), .LOOKUP_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .sim_clk(sim_a), .ch_en(en_a), .ch_state(st_a),
        .tile_x(tx_a), .tile_y(ty_a), .tile_type(tt_a), .col(col_a),
        .busy(busy_a), .done(done_a), .overrun(ovr_a)
`ifdef RESOLVE_POS_EN
        , .res_pos(pos_a)
`endif
    );

    entity_collision_scheduler #(.N_CH(4), .LOOKUP_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .sim_clk(sim_b), .ch_en(en_b), .ch_state(st_b),
        .tile_x(tx_b), .tile_y(ty_b), .tile_type(tt_b), .col(col_b),
        .busy(busy_b), .done(done_b), .overrun(ovr_b)
`ifdef RESOLVE_POS_EN
        , .res_pos(pos_b)
`endif
    );

    function automatic logic [2:0] map_f(input int mode, input logic [9:0] x, input logic [9:0] y);
        case (mode)
            1:       return (x >= 10'd133) ? 3'd1 : 3'd0;
            2:       return (y >= 10'd200) ? 3'd2 : 3'd0;
            3:       return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] mk(input int x, input int y, input int xs, input int ys,
                                       input logic xd, input logic yd);
        return {10'(x), 10'(y), 5'(xs), 5'(ys), xd, yd};
    endfunction

    logic [2:0] pa;
    logic [2:0] pb [3];
    always @(posedge clk) begin
        pa    <= map_f(mode_a, tx_a, ty_a);
        pb[0] <= map_f(mode_b, tx_b, ty_b);
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign tt_a = pa;
    assign tt_b = pb[2];

    int         lat_a, lat_b;
    logic [9:0] prx [4];
    logic [9:0] pry [4];
    logic       done_w, busy_w;

    task automatic frame_a(input logic [31:0] st, input int mode);
        int n;
        @(negedge clk);
        st_a = st; mode_a = mode; sim_a = 1'b1;
        n = 0;
        while (!busy_a && n < 10) begin @(negedge clk); n++; end
        lat_a = -1;
        if (busy_a) begin
            lat_a = 0;
            while (!done_a && lat_a < 200) begin
                @(negedge clk);
                lat_a++;
                if (lat_a <= 4) begin prx[lat_a-1] = tx_a; pry[lat_a-1] = ty_a; end
            end
        end
        @(negedge clk);
        done_w = done_a; busy_w = busy_a;
        sim_a = 1'b0;
        repeat (3) @(negedge clk);
        $display("frame a: state=%h map=%0d lat=%0d col=%b", st, mode, lat_a, col_a);
    endtask

    task automatic frame_b(input logic [31:0] st, input logic [3:0] en);
        int n;
        @(negedge clk);
        st_b = {4{st}}; en_b = en; sim_b = 1'b1;
        n = 0;
        while (!busy_b && n < 10) begin @(negedge clk); n++; end
        lat_b = -1;
        if (busy_b) begin
            lat_b = 0;
            while (!done_b && lat_b < 200) begin
                @(negedge clk);
                lat_b++;
                if (lat_b == 1) begin en_b = ~en; st_b = '0; end
            end
        end
        @(negedge clk);
        sim_b = 1'b0;
        repeat (3) @(negedge clk);
        $display("frame b: state=%h en=%b lat=%0d col=%h", st, en, lat_b, col_b);
    endtask

    task automatic test_reset();
        int n;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        sim_a = 1'b1; sim_b = 1'b0;
        en_a = 1'b1; st_a = '0; en_b = '0; st_b = '0;
        repeat (3) @(negedge clk);
        total++; if (col_a !== 4'd0) begin bad++; $display("FAIL reset_col_a got=%b exp=0000", col_a); end
        total++; if ({tx_a, ty_a} !== 20'd0) begin bad++; $display("FAIL reset_tile_a got=%0d,%0d exp=0,0", tx_a, ty_a); end
        total++; if ({busy_a, done_a, ovr_a} !== 3'b000) begin bad++; $display("FAIL reset_flags_a got=%b exp=000", {busy_a, done_a, ovr_a}); end
        total++; if (col_b !== 16'd0) begin bad++; $display("FAIL reset_col_b got=%h exp=0000", col_b); end
        total++; if ({tx_b, ty_b, busy_b, done_b, ovr_b} !== 23'd0) begin bad++; $display("FAIL reset_misc_b got=%h exp=0", {tx_b, ty_b, busy_b, done_b, ovr_b}); end
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        n = 0;
        while (!busy_a && n < 10) begin @(negedge clk); n++; end
        total++; if (n !== 3) begin bad++; $display("FAIL start_after_release got=%0d exp=3", n); end
        n = 0;
        while (busy_a && n < 50) begin @(negedge clk); n++; end
        sim_a = 1'b0;
        repeat (3) @(negedge clk);
        $display("reset: start delay checked, release frame took %0d cycles", n);
    endtask

    task automatic test_empty_map();
        frame_a(mk(100, 200, 4, 0, 1'b1, 1'b0), 0);
        total++; if (lat_a !== 11) begin bad++; $display("FAIL empty_latency got=%0d exp=11", lat_a); end
        total++; if (col_a !== 4'b0000) begin bad++; $display("FAIL empty_col got=%b exp=0000", col_a); end
        total++; if ({prx[0], pry[0]} !== {10'd104, 10'd200}) begin bad++; $display("FAIL probe_bl got=%0d,%0d exp=104,200", prx[0], pry[0]); end
        total++; if ({prx[1], pry[1]} !== {10'd104, 10'd169}) begin bad++; $display("FAIL probe_ul got=%0d,%0d exp=104,169", prx[1], pry[1]); end
        total++; if ({prx[2], pry[2]} !== {10'd135, 10'd169}) begin bad++; $display("FAIL probe_ur got=%0d,%0d exp=135,169", prx[2], pry[2]); end
        total++; if ({done_w, busy_w} !== 2'b00) begin bad++; $display("FAIL done_pulse got=%b exp=00", {done_w, busy_w}); end
`ifdef RESOLVE_POS_EN
        total++; if (pos_a !== {10'd104, 10'd200}) begin bad++; $display("FAIL empty_pos got=%h exp=%h", pos_a, {10'd104, 10'd200}); end
`endif
    endtask

    task automatic test_solid_right();
        frame_a(mk(100, 200, 4, 0, 1'b1, 1'b0), 1);
        total++; if (col_a !== 4'b0100) begin bad++; $display("FAIL solid_right_col got=%b exp=0100", col_a); end
`ifdef RESOLVE_POS_EN
        total++; if (pos_a !== {10'd100, 10'd200}) begin bad++; $display("FAIL solid_right_pos got=%h exp=%h", pos_a, {10'd100, 10'd200}); end
`endif
    endtask

    task automatic test_oneway();
        frame_a(mk(100, 200, 0, 3, 1'b0, 1'b0), 2);
        total++; if (col_a !== 4'b0010) begin bad++; $display("FAIL oneway_down got=%b exp=0010", col_a); end
        frame_a(mk(100, 200, 0, 3, 1'b0, 1'b1), 2);
        total++; if (col_a !== 4'b0000) begin bad++; $display("FAIL oneway_up got=%b exp=0000", col_a); end
    endtask

    task automatic test_offmap();
        frame_a(mk(2, 200, 5, 0, 1'b0, 1'b0), 0);
        total++; if (col_a !== 4'b0001) begin bad++; $display("FAIL offmap_left got=%b exp=0001", col_a); end
        total++; if (prx[0] !== 10'd1021) begin bad++; $display("FAIL offmap_wrap got=%0d exp=1021", prx[0]); end
        frame_a(mk(100, 470, 0, 12, 1'b0, 1'b0), 0);
        total++; if (col_a !== 4'b0010) begin bad++; $display("FAIL offmap_bottom got=%b exp=0010", col_a); end
    endtask

    task automatic test_multi_channel();
        mode_b = 3;
        frame_b(mk(100, 200, 2, 2, 1'b0, 1'b1), 4'b1010);
        total++; if (lat_b !== 57) begin bad++; $display("FAIL multi_latency got=%0d exp=57", lat_b); end
        total++; if (col_b !== 16'h9090) begin bad++; $display("FAIL multi_col got=%h exp=9090", col_b); end
    endtask

    task automatic test_overrun();
        int n, dones;
        @(negedge clk);
        st_a = mk(100, 200, 0, 0, 1'b0, 1'b0); mode_a = 0; sim_a = 1'b1;
        n = 0;
        while (!busy_a && n < 10) begin @(negedge clk); n++; end
        sim_a = 1'b0;
        repeat (2) @(negedge clk);
        sim_a = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (done_a) dones++; end
        sim_a = 1'b0;
        repeat (3) @(negedge clk);
        $display("overrun: dones=%0d overrun=%b", dones, ovr_a);
        total++; if (ovr_a !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b exp=1", ovr_a); end
        total++; if (dones !== 1) begin bad++; $display("FAIL overrun_single_done got=%0d exp=1", dones); end
    endtask

    task automatic test_reset_mid_frame();
        int n, dones;
        @(negedge clk); rst_a_n = 1'b0;
        @(negedge clk);
        total++; if (ovr_a !== 1'b0) begin bad++; $display("FAIL overrun_clear got=%b exp=0", ovr_a); end
        rst_a_n = 1'b1;
        repeat (3) @(negedge clk);
        st_a = mk(100, 200, 4, 0, 1'b1, 1'b0); mode_a = 3; sim_a = 1'b1;
        n = 0;
        while (!busy_a && n < 10) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        rst_a_n = 1'b0;
        #1;
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy_a); end
        sim_a = 1'b0;
        @(negedge clk); rst_a_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 30; i++) begin @(negedge clk); if (done_a) dones++; end
        $display("mid-frame reset: dones=%0d col=%b", dones, col_a);
        total++; if (col_a !== 4'b0000) begin bad++; $display("FAIL abort_col got=%b exp=0000", col_a); end
        total++; if (dones !== 0) begin bad++; $display("FAIL abort_done got=%0d exp=0", dones); end
    endtask

    initial begin
        test_reset();
        test_empty_map();
        test_solid_right();
        test_oneway();
        test_offmap();
        test_multi_channel();
        test_overrun();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
